// File: rtl/mac_tx_framer.sv
// mac_tx_framer
// ---------------------------------------------------------------------------
// Transmit MAC framer for a single-lane 64b 10GBASE-R PCS transmit path.
// Converts a valid/ready packet stream into per-cycle XGMII-style block flags
// (control / idle / start / terminate / error), block data and keep for the
// 64b/66b encoder.
//
// Block encoding on the outputs (all registered):
//   IDLE  : ctrl=1 idle=1                 data=0                keep=0
//   START : ctrl=1 start=2'b01            data=D5555555555555FB keep=FF
//   DATA  : ctrl=0                        data=beat             keep=FF
//   TERM  : ctrl=1 term=1                 data=beat, unused bytes 0, keep=beat keep
//   ERR   : ctrl=1 err=1                  data=0                keep=0
// A start is only ever placed in lane 0 (start_v_o = 2'b01).
//
// Parameters:
//   DATA_W  - data width (64 for 10G)
//   KEEP_W  - byte enables (DATA_W/8)
//   IPG_CYC - idle gap control after terminate/error blocks (0..15)
//
// Ports:
//   clk, nreset                  - clock, asynchronous active-low reset
//   s_valid_i / s_ready_o        - upstream handshake (s_ready_o combinational)
//   s_data_i, s_keep_i           - beat data (byte 0 in [7:0]) and byte enables
//   s_last_i, s_err_i            - end-of-frame, abort-frame-at-this-beat
//   ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o - block type flags
//   data_o, keep_o               - block data / valid bytes of a terminate
//
// Optional build macro MAC_TX_FRAMER_STATS_EN adds:
//   frame_cnt_o[31:0] - terminate blocks emitted (wraps)
//   abort_cnt_o[31:0] - error blocks emitted (wraps)
// ---------------------------------------------------------------------------
module mac_tx_framer #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int IPG_CYC = 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic [KEEP_W-1:0] s_keep_i,
    input  logic              s_last_i,
    input  logic              s_err_i,
    output logic              ctrl_v_o,
    output logic              idle_v_o,
    output logic [1:0]        start_v_o,
    output logic              term_v_o,
    output logic              err_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o
`ifdef MAC_TX_FRAMER_STATS_EN
    ,
    output logic [31:0]       frame_cnt_o,
    output logic [31:0]       abort_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_TERM0,
        ST_DRAIN,
        ST_IPG
    } state_t;

    localparam logic [DATA_W-1:0] START_DATA = DATA_W'(64'hD5555555555555FB);
    localparam logic [3:0]        IPG_LOAD   = 4'(IPG_CYC);
    // With no gap configured, the end of a frame returns straight to IDLE.
    localparam state_t            AFTER_END  = (IPG_CYC == 0) ? ST_IDLE : ST_IPG;

    state_t            state_reg;
    logic [3:0]        ipg_cnt_reg;
    logic [DATA_W-1:0] term_data;
    logic              keep_full;

    // Beats are only taken while a frame is open or being drained.
    assign s_ready_o = (state_reg == ST_SOF) || (state_reg == ST_DATA) ||
                       (state_reg == ST_DRAIN);

    // A last beat with keep=0 is treated as a full beat.
    assign keep_full = (s_keep_i == {KEEP_W{1'b1}}) || (s_keep_i == {KEEP_W{1'b0}});

    // Terminate data: bytes beyond the keep boundary are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < KEEP_W; gi++) begin : g_term_mask
            assign term_data[gi*8 +: 8] = s_keep_i[gi] ? s_data_i[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Framing FSM. Every branch writes the block that appears on the outputs
    // in the following cycle; the IDLE block is the default.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg   <= ST_IDLE;
            ipg_cnt_reg <= 4'd0;
            ctrl_v_o    <= 1'b1;
            idle_v_o    <= 1'b1;
            start_v_o   <= 2'b00;
            term_v_o    <= 1'b0;
            err_v_o     <= 1'b0;
            data_o      <= '0;
            keep_o      <= '0;
        end else begin
            ctrl_v_o  <= 1'b1;
            idle_v_o  <= 1'b1;
            start_v_o <= 2'b00;
            term_v_o  <= 1'b0;
            err_v_o   <= 1'b0;
            data_o    <= '0;
            keep_o    <= '0;

            case (state_reg)
                ST_IDLE: begin
                    // START is emitted on sight of a valid beat; the beat
                    // itself is consumed in SOF.
                    if (s_valid_i) begin
                        idle_v_o  <= 1'b0;
                        start_v_o <= 2'b01;
                        data_o    <= START_DATA;
                        keep_o    <= '1;
                        state_reg <= ST_SOF;
                    end
                end

                ST_SOF, ST_DATA: begin
                    if (!s_valid_i) begin
                        // Underrun inside a frame: abort and drop the rest.
                        idle_v_o  <= 1'b0;
                        err_v_o   <= 1'b1;
                        state_reg <= ST_DRAIN;
                    end else if (s_err_i) begin
                        idle_v_o <= 1'b0;
                        err_v_o  <= 1'b1;
                        if (s_last_i) begin
                            state_reg   <= AFTER_END;
                            ipg_cnt_reg <= IPG_LOAD;
                        end else begin
                            state_reg <= ST_DRAIN;
                        end
                    end else if (!s_last_i || keep_full) begin
                        // Full beat; a full last beat still needs a
                        // separate keep=0 terminate afterwards.
                        ctrl_v_o  <= 1'b0;
                        idle_v_o  <= 1'b0;
                        data_o    <= s_data_i;
                        keep_o    <= '1;
                        state_reg <= s_last_i ? ST_TERM0 : ST_DATA;
                    end else begin
                        // Partial last beat folds into the terminate block.
                        idle_v_o    <= 1'b0;
                        term_v_o    <= 1'b1;
                        data_o      <= term_data;
                        keep_o      <= s_keep_i;
                        state_reg   <= AFTER_END;
                        ipg_cnt_reg <= IPG_LOAD;
                    end
                end

                ST_TERM0: begin
                    idle_v_o    <= 1'b0;
                    term_v_o    <= 1'b1;
                    state_reg   <= AFTER_END;
                    ipg_cnt_reg <= IPG_LOAD;
                end

                ST_DRAIN: begin
                    // Beats are accepted and thrown away up to the frame end.
                    if (s_valid_i && s_last_i) begin
                        state_reg   <= AFTER_END;
                        ipg_cnt_reg <= IPG_LOAD;
                    end
                end

                ST_IPG: begin
                    // Counts down to zero, so together with the IDLE-state
                    // cycle the line sees IPG_CYC+1 idle blocks after a
                    // terminate before the next START.
                    if (ipg_cnt_reg == 4'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        ipg_cnt_reg <= ipg_cnt_reg - 4'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MAC_TX_FRAMER_STATS_EN
    logic [31:0] frame_cnt_reg;
    logic [31:0] abort_cnt_reg;

    // Counted from the registered block flags: each flag is high for exactly
    // one cycle per emitted terminate / error block.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            frame_cnt_reg <= 32'd0;
            abort_cnt_reg <= 32'd0;
        end else begin
            if (term_v_o) begin
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            end
            if (err_v_o) begin
                abort_cnt_reg <= abort_cnt_reg + 32'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_reg;
    assign abort_cnt_o = abort_cnt_reg;
`endif

endmodule
